// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, debounce FSM, mode-qualified
// one-cycle event pulse, sticky flag and saturating event counter.
module multi_edge_detect #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic [1:0]               mode,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         level,
  output logic [WIDTH-1:0]         sticky,
  output logic [WIDTH*CNT_W-1:0]   count,
  output logic                     any_event
);

  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} state_t;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   rise_c, fall_c, ev_c;
    logic                   out_q, level_q, sticky_q;
    logic [CNT_W-1:0]       count_q;

    // Synchroniser chain; s is the last stage
    always_ff @(posedge clk) begin
      if (!reset) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= in[i];
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= LOW;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Debounce next-state; rise/fall flag the edge that enters HIGH/LOW
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_c  = 1'b0;
      fall_c  = 1'b0;
      unique case (state_q)
        LOW: begin
          if (s) begin
            if (DEBOUNCE == 1) begin
              state_d = HIGH;
              cnt_d   = '0;
              rise_c  = 1'b1;
            end else begin
              state_d = CHK_H;
              cnt_d   = DB_W'(1);
            end
          end
        end
        CHK_H: begin
          if (s) begin
            if (DB_W'(cnt_q + DB_W'(1)) == DB_W'(DEBOUNCE)) begin
              state_d = HIGH;
              cnt_d   = '0;
              rise_c  = 1'b1;
            end else begin
              cnt_d = DB_W'(cnt_q + DB_W'(1));
            end
          end else begin
            state_d = LOW;
            cnt_d   = '0;
          end
        end
        HIGH: begin
          if (!s) begin
            if (DEBOUNCE == 1) begin
              state_d = LOW;
              cnt_d   = '0;
              fall_c  = 1'b1;
            end else begin
              state_d = CHK_L;
              cnt_d   = DB_W'(1);
            end
          end
        end
        CHK_L: begin
          if (!s) begin
            if (DB_W'(cnt_q + DB_W'(1)) == DB_W'(DEBOUNCE)) begin
              state_d = LOW;
              cnt_d   = '0;
              fall_c  = 1'b1;
            end else begin
              cnt_d = DB_W'(cnt_q + DB_W'(1));
            end
          end else begin
            state_d = HIGH;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
      ev_c = (rise_c & mode[0]) | (fall_c & mode[1]);
    end

    // Event outputs; an event on the clear edge leaves the channel at sticky=1, count=1
    always_ff @(posedge clk) begin
      if (!reset) begin
        out_q    <= 1'b0;
        level_q  <= 1'b0;
        sticky_q <= 1'b0;
        count_q  <= '0;
      end else begin
        out_q   <= ev_c;
        level_q <= (state_d == HIGH) || (state_d == CHK_L);
        if (clear) begin
          sticky_q <= ev_c;
          count_q  <= ev_c ? CNT_W'(1) : '0;
        end else if (ev_c) begin
          sticky_q <= 1'b1;
          if (count_q != CNT_MAX) count_q <= CNT_W'(count_q + CNT_W'(1));
        end
      end
    end

    assign out[i]                    = out_q;
    assign level[i]                  = level_q;
    assign sticky[i]                 = sticky_q;
    assign count[i*CNT_W +: CNT_W]   = count_q;
  end

  assign any_event = |out;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed self-checking bench for multi_edge_detect (4 channels, 2 sync, debounce 3, 2-bit counters).
module tb_multi_edge_detect;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [WIDTH-1:0]       in;
  logic [1:0]             mode;
  logic                   clear;
  logic [WIDTH-1:0]       out, level, sticky;
  logic [WIDTH*CNT_W-1:0] count;
  logic                   any_event;

  int checks   = 0;
  int failures = 0;

  multi_edge_detect #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .clear(clear),
    .out(out), .level(level), .sticky(sticky), .count(count), .any_event(any_event)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int ch);
    logic [WIDTH*CNT_W-1:0] c;
    c = count;
    return 32'(c[ch*CNT_W +: CNT_W]);
  endfunction

  initial begin
    reset = 1'b0; in = '0; mode = 2'b11; clear = 1'b0;

    // Reset
    tick(2);
    check("rst_out",    32'(out),       32'h0);
    check("rst_level",  32'(level),     32'h0);
    check("rst_sticky", 32'(sticky),    32'h0);
    check("rst_count",  32'(count),     32'h0);
    check("rst_any",    32'(any_event), 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_out", 32'(out), 32'h0);
    end

    // Rise/fall latency on channel 0, mode both
    in[0] = 1'b1;
    tick(4);
    check("rise_early_out",   32'(out),      32'h0);
    check("rise_early_level", 32'(level[0]), 32'h0);
    tick();
    check("rise_out",    32'(out),       32'h1);
    check("rise_any",    32'(any_event), 32'h1);
    check("rise_level",  32'(level[0]),  32'h1);
    check("rise_count",  cnt(0),         32'h1);
    check("rise_sticky", 32'(sticky[0]), 32'h1);
    tick();
    check("rise_pulse_end", 32'(out), 32'h0);
    tick(4);
    in[0] = 1'b0;
    tick(4);
    check("fall_early_out",   32'(out),      32'h0);
    check("fall_early_level", 32'(level[0]), 32'h1);
    tick();
    check("fall_out",    32'(out),       32'h1);
    check("fall_level",  32'(level[0]),  32'h0);
    check("fall_count",  cnt(0),         32'h2);
    check("fall_sticky", 32'(sticky[0]), 32'h1);
    tick();
    check("fall_pulse_end", 32'(out), 32'h0);

    // Glitch rejection on channel 1
    for (int r = 0; r < 5; r++) begin
      in[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin tick(); check("glitch_out", 32'(out), 32'h0); end
      in[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin tick(); check("glitch_out", 32'(out), 32'h0); end
    end
    tick(4);
    check("glitch_out_tail", 32'(out),       32'h0);
    check("glitch_level",    32'(level[1]),  32'h0);
    check("glitch_count",    cnt(1),         32'h0);
    check("glitch_sticky",   32'(sticky[1]), 32'h0);

    // Mode filtering on channel 2: rising only, then none
    mode = 2'b01;
    for (int r = 0; r < 2; r++) begin
      in[2] = 1'b1; tick(12); check("mode01_level_hi", 32'(level[2]), 32'h1);
      in[2] = 1'b0; tick(12); check("mode01_level_lo", 32'(level[2]), 32'h0);
    end
    check("mode01_count", cnt(2), 32'h2);
    mode = 2'b00;
    in[2] = 1'b1; tick(12); check("mode00_level_hi", 32'(level[2]), 32'h1);
    in[2] = 1'b0; tick(12); check("mode00_level_lo", 32'(level[2]), 32'h0);
    check("mode00_count", cnt(2), 32'h2);

    // Saturation then clear collision on channel 3
    mode = 2'b01;
    for (int r = 1; r <= 5; r++) begin
      in[3] = 1'b1; tick(8);
      in[3] = 1'b0; tick(8);
      if (r == 1) check("sat_count_1", cnt(3), 32'h1);
      if (r == 3) check("sat_count_3", cnt(3), 32'h3);
    end
    check("sat_count_5", cnt(3), 32'h3);
    in[3] = 1'b1;
    tick(4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_out",     32'(out),    32'h8);
    check("clr_count3",  cnt(3),      32'h1);
    check("clr_sticky",  32'(sticky), 32'h8);
    check("clr_count0",  cnt(0),      32'h0);
    check("clr_count2",  cnt(2),      32'h0);
    tick();
    check("clr_hold_count3", cnt(3),   32'h1);
    check("clr_hold_out",    32'(out), 32'h0);
    in[3] = 1'b0;
    tick(8);

    // Simultaneous rise on all channels, mode both
    mode = 2'b11;
    in = 4'b1111;
    tick(4);
    check("sim_early_out", 32'(out), 32'h0);
    tick();
    check("sim_out", 32'(out),       32'hf);
    check("sim_any", 32'(any_event), 32'h1);
    tick();
    check("sim_out_end", 32'(out),       32'h0);
    check("sim_any_end", 32'(any_event), 32'h0);

    // Reset with inputs held high, then one rise event after release
    clear = 1'b1;
    reset = 1'b0;
    tick();
    check("rst2_level",  32'(level),  32'h0);
    check("rst2_count",  32'(count),  32'h0);
    check("rst2_sticky", 32'(sticky), 32'h0);
    clear = 1'b0;
    reset = 1'b1;
    tick(4);
    check("rst2_early_out", 32'(out), 32'h0);
    tick();
    check("rst2_rise_out", 32'(out),   32'hf);
    check("rst2_level_hi", 32'(level), 32'hf);
    tick();
    check("rst2_out_end", 32'(out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
